// File: rtl/serial_nibble_adder.sv
// serial_nibble_adder: a WIDTH-bit adder built from a single 4-bit adder.
// One nibble is added per clock, least significant nibble first, and the
// carry is held in a register between nibbles. Both operands and the result
// use valid/ready handshakes.
// Optional feature: define SERIAL_ADDER_OVF_FLAG_EN to add the signed-overflow
// output 'ovf'.

module adder4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = 5'(a) + 5'(b) + 5'(cin);

endmodule

module serial_nibble_adder #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_FLAG_EN
  ,
  output logic             ovf
`endif
);

  // The slice counter is one bit wide when NIBBLES=1, so it never has zero width.
  localparam int              CNT_W    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             carry_q;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic [3:0]       nib_sum;
  logic             nib_cout;

  // The latched operands feed the adder one nibble at a time. The input ports
  // are not used here, so changes on them during RUN have no effect.
  assign nib_a = a_q[4*cnt +: 4];
  assign nib_b = b_q[4*cnt +: 4];

  adder4 u_adder4 (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  // in_ready decodes the state register directly. It is high in IDLE and
  // during reset, and it is not high in the cycle of the result handshake.
  assign in_ready = (state == IDLE);

`ifdef SERIAL_ADDER_OVF_FLAG_EN
  // The carry into the MSB can be recovered from the top nibble's bit 3:
  // carry_in = a ^ b ^ sum at that bit.
  logic msb_carry_in;
  assign msb_carry_in = nib_a[3] ^ nib_b[3] ^ nib_sum[3];
`endif

  // Control FSM and datapath registers. Async reset aborts any operation in progress.
  // NOTE: sequential state uses non-blocking (<=) assignments only. Every
  // register then samples values from before the edge, which avoids races
  // between always blocks that share the same clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      carry_q   <= 1'b0;
      cnt       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[4*cnt +: 4] <= nib_sum;
          carry_q         <= nib_cout;
          if (cnt == LAST_CNT) begin
            cnt       <= '0;
            cout      <= nib_cout;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
            ovf       <= msb_carry_in ^ nib_cout;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_nibble_adder.sv
// Testbench for serial_nibble_adder (NIBBLES=4). A behavioural model tracks
// the expected handshake timing and result by plain arithmetic, and is
// compared against the DUT on every falling edge. Directed tests also check
// literal, hand-computed values.
// Define SERIAL_ADDER_OVF_FLAG_EN to enable the ovf checks.

module tb_serial_nibble_adder;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_FLAG_EN
  logic         ovf;
`endif

  int total  = 0;
  int passed = 0;

  serial_nibble_adder #(.NIBBLES(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef SERIAL_ADDER_OVF_FLAG_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // The model knows four things: whether the block is free to accept, the
  // cycle at which the result must appear, the expected result, and whether
  // the block has been cleared by reset and has not accepted anything since.
  bit           m_free  = 1'b1;
  bit           m_valid = 1'b0;
  bit           m_zero  = 1'b1;
  int           cycle   = 0;
  int           m_due   = 0;
  logic [W-1:0] m_sum   = '0;
  logic         m_cout  = 1'b0;
  logic         m_ovf   = 1'b0;
  int           acc_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_free  = 1'b1;
      m_valid = 1'b0;
      m_zero  = 1'b1;
    end else begin
      cycle++;
      if (m_valid) begin
        if (out_ready) begin
          m_valid = 1'b0;
          m_free  = 1'b1;
        end
      end else if (m_free) begin
        if (in_valid) begin
          logic [W:0] full;
          int         s;
          full    = (W+1)'(a) + (W+1)'(b) + (W+1)'(cin);
          s       = $signed(a) + $signed(b) + int'(cin);
          m_sum   = full[W-1:0];
          m_cout  = full[W];
          m_ovf   = (s > 32767) || (s < -32768);
          m_free  = 1'b0;
          m_zero  = 1'b0;
          m_due   = cycle + N;
        end
      end else if (cycle == m_due) begin
        m_valid = 1'b1;
      end
    end
  end

  // Compare the DUT with the model on every falling edge. Accepts seen on the
  // DUT ports are also recorded here.
  always @(negedge clk) begin
    check("in_ready", in_ready, m_free);
    check("out_valid", out_valid, m_valid);
    if (m_valid || m_zero) begin
      check("sum", sum, m_zero ? '0 : m_sum);
      check("cout", cout, m_zero ? 1'b0 : m_cout);
`ifdef SERIAL_ADDER_OVF_FLAG_EN
      check("ovf", ovf, m_zero ? 1'b0 : m_ovf);
`endif
    end
    if (rst_n && in_valid && in_ready) acc_q.push_back(cycle + 1);
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                       input logic [W-1:0] es, input logic ec, input logic eo);
    int k;
    k = 0;
    out_ready = 1'b0;
    while (!in_ready && k < 50) begin tick; k++; end
    in_valid = 1'b1; a = ta; b = tb; cin = tc;
    tick;
    in_valid = 1'b0;
    k = 0;
    while (!out_valid && k < 50) begin tick; k++; end
    check("latency", k, N);
    check("op_sum", sum, es);
    check("op_cout", cout, ec);
`ifdef SERIAL_ADDER_OVF_FLAG_EN
    check("op_ovf", ovf, eo);
`else
    if (eo) begin end
`endif
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check("idle_after_handshake", {in_ready, out_valid}, 2'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    logic [W-1:0] res[$];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    tick;
    tick;
    check("reset_state", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h0000});
    rst_n = 1'b1;
    tick;

    do_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    do_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    do_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    do_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // Backpressure: the result must stay held while new operands are offered.
    in_valid = 1'b1; a = 16'hABCD; b = 16'h1111; cin = 1'b0;
    tick;
    a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1;
    k = 0;
    while (!out_valid && k < 50) begin tick; k++; end
    for (int i = 0; i < 5; i++) begin
      tick;
      check("bp_hold", {out_valid, in_ready, cout, sum}, {1'b1, 1'b0, 1'b0, 16'hBCDE});
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    check("bp_release", {in_ready, out_valid}, 2'b10);

    // Back-to-back: in_valid and out_ready held high.
    acc_q.delete();
    in_valid = 1'b1; out_ready = 1'b1; a = 16'h0001; b = 16'h0002; cin = 1'b0;
    tick;
    a = 16'hFFFE; b = 16'h0001;
    k = 0;
    while (res.size() < 2 && k < 40) begin
      tick; k++;
      if (acc_q.size() >= 2) in_valid = 1'b0;
      if (out_valid) res.push_back(sum);
    end
    tick;
    in_valid = 1'b0; out_ready = 1'b0;
    check("b2b_count", res.size(), 2);
    if (res.size() == 2) begin
      check("b2b_sum0", res[0], 16'h0003);
      check("b2b_sum1", res[1], 16'hFFFF);
    end
    check("b2b_accepts", acc_q.size(), 2);
    if (acc_q.size() >= 2) check("b2b_spacing", acc_q[1] - acc_q[0], N + 2);

    // Reset in the middle of RUN.
    in_valid = 1'b1; a = 16'h1234; b = 16'h0001; cin = 1'b0;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    rst_n = 1'b0;
    #1;
    check("midrun_reset", {in_ready, out_valid, cout, sum}, {1'b1, 1'b0, 1'b0, 16'h0000});
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick;
      check("no_stale", {out_valid, sum}, {1'b0, 16'h0000});
    end

    do_op(16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0);

    tick;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
